// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: two RW registers (REG0/REG1) plus read-only WCOUNT and SUM.
// Write and read channels run as independent two-state FSMs with registered outputs.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e              w_state_q;
    r_state_e              r_state_q;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB-1:0]       wstrb_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] reg0_q, reg1_q, wcount_q;
    logic [DATA_WIDTH-1:0] reg0_d, reg1_d, wcount_d;
    logic [1:0]            wr_resp_d, rd_resp_d;
    logic [DATA_WIDTH-1:0] rd_data_d, merged_d;

    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB-1:0]       wr_strb;
    logic                  unused_strb_msb;

    assign unused_strb_msb = s0_axi_wstrb[STRB];

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // once a valid is raised by this slave, it and its payload hold until the matching ready.
    assign aw_hs   = s0_axi_awvalid && awready_q;
    assign w_hs    = s0_axi_wvalid && wready_q;
    assign wr_addr = aw_hs ? s0_axi_awaddr : awaddr_q;
    assign wr_data = w_hs ? s0_axi_wdata : wdata_q;
    assign wr_strb = w_hs ? s0_axi_wstrb[STRB-1:0] : wstrb_q;
    assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    always_comb begin
        reg0_d    = reg0_q;
        reg1_d    = reg1_q;
        wcount_d  = wcount_q;
        merged_d  = wr_addr[2] ? reg1_q : reg0_q;
        wr_resp_d = RESP_OKAY;
        if (wr_addr[1:0] != 2'b00 || wr_addr[ADDR_WIDTH-1:4] != '0) begin
            wr_resp_d = RESP_DECERR;
        end else if (wr_addr[3]) begin
            wr_resp_d = RESP_SLVERR;
        end
        for (int i = 0; i < STRB; i++) begin
            if (wr_strb[i]) begin
                merged_d[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        if (commit && wr_resp_d == RESP_OKAY) begin
            wcount_d = wcount_q + DATA_WIDTH'(1);
            if (wr_addr[2]) begin
                reg1_d = merged_d;
            end else begin
                reg0_d = merged_d;
            end
        end
    end

    // Reads see register state before any write committing on the same edge.
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_DECERR;
        if (s0_axi_araddr[1:0] == 2'b00 && s0_axi_araddr[ADDR_WIDTH-1:4] == '0) begin
            rd_resp_d = RESP_OKAY;
            case (s0_axi_araddr[3:2])
                2'd0:    rd_data_d = reg0_q;
                2'd1:    rd_data_d = reg1_q;
                2'd2:    rd_data_d = wcount_q;
                default: rd_data_d = reg0_q + reg1_q;
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            reg0_q    <= '0;
            reg1_q    <= '0;
            wcount_q  <= '0;
        end else begin
            reg0_q   <= reg0_d;
            reg1_q   <= reg1_d;
            wcount_q <= wcount_d;
            case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp_d;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        w_state_q <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s0_axi_awaddr;
                            awready_q <= 1'b0;
                        end else begin
                            awready_q <= !aw_held_q;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s0_axi_wdata;
                            wstrb_q  <= s0_axi_wstrb[STRB-1:0];
                            wready_q <= 1'b0;
                        end else begin
                            wready_q <= !w_held_q;
                        end
                    end
                end
                default: begin
                    if (s0_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s0_axi_arvalid && arready_q) begin
                        rdata_q   <= rd_data_d;
                        rresp_q   <= rd_resp_d;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    if (s0_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign s0_axi_awready = awready_q;
    assign s0_axi_wready  = wready_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = RESP_WIDTH'(bresp_q);
    assign s0_axi_arready = arready_q;
    assign s0_axi_rvalid  = rvalid_q;
    assign s0_axi_rresp   = RESP_WIDTH'(rresp_q);
    assign s0_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: register map, error responses, latency,
// throughput, same-cycle read/write ordering, backpressure and mid-transaction reset.
module tb_axi_lite_reg_slave;
    logic        clk;
    logic        areset;
    logic [7:0]  awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid, wready;
    logic [2:0]  bresp;
    logic        bvalid, bready;
    logic [7:0]  araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    axi_lite_reg_slave dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (areset),
        .s0_axi_awaddr (awaddr),
        .s0_axi_awvalid(awvalid),
        .s0_axi_awready(awready),
        .s0_axi_wdata  (wdata),
        .s0_axi_wstrb  (wstrb),
        .s0_axi_wvalid (wvalid),
        .s0_axi_wready (wready),
        .s0_axi_bresp  (bresp),
        .s0_axi_bvalid (bvalid),
        .s0_axi_bready (bready),
        .s0_axi_araddr (araddr),
        .s0_axi_arvalid(arvalid),
        .s0_axi_arready(arready),
        .s0_axi_rdata  (rdata),
        .s0_axi_rresp  (rresp),
        .s0_axi_rvalid (rvalid),
        .s0_axi_rready (rready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [4:0] strb, output logic [2:0] resp);
        logic aw_done, w_done, got_b, hs_aw, hs_w;
        aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0;
        resp    = 3'b111;
        awaddr  = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step();
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (bvalid) begin resp = bresp; got_b = 1'b1; end
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done && got_b)) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout: addr %h not completed (aw %0b w %0b b %0b), required completion",
                     addr, aw_done, w_done, got_b);
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
        logic ar_done, got_r;
        ar_done = 1'b0; got_r = 1'b0;
        data = 32'hxxxx_xxxx; resp = 3'b111;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_done = arready;
            step();
        end
        arvalid = 1'b0;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (rvalid) begin data = rdata; resp = rresp; got_r = 1'b1; end
            step();
        end
        if (!(ar_done && got_r)) begin
            n_tests++; n_fail++;
            $display("FAIL read_timeout: addr %h not completed (ar %0b r %0b), required completion",
                     addr, ar_done, got_r);
        end
    endtask

    // scenarios
    task automatic test_reset();
        logic [31:0] d; logic [2:0] r;
        areset = 1'b1;
        step(); step();
        n_tests++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        n_tests++;
        if ({bresp, rresp, rdata} !== 38'd0) begin
            n_fail++; $display("FAIL reset_data: got bresp %h rresp %h rdata %h required 0", bresp, rresp, rdata);
        end
        areset = 1'b0;
        step();
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++; $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
        end
        axi_read(8'h0, d, r);
        n_tests++;
        if ({r, d} !== {3'd0, 32'h0}) begin
            n_fail++; $display("FAIL reset_reg0: got resp %h data %h required 0 00000000", r, d);
        end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] d; logic [2:0] r;
        awaddr = 8'h0; wdata = 32'hDEADBEEF; wstrb = 5'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if ({bvalid, bresp, awready, wready} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL same_cycle_b: got bvalid %b bresp %h aw/w ready %b%b required 1 0 00",
                               bvalid, bresp, awready, wready);
        end
        bready = 1'b1;
        step();
        n_tests++;
        if (bvalid !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_bclear: got bvalid %b required 0", bvalid);
        end
        axi_read(8'h0, d, r);
        n_tests++;
        if ({r, d} !== {3'd0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL same_cycle_reg0: got resp %h data %h required 0 deadbeef", r, d);
        end
        axi_read(8'h8, d, r);
        n_tests++;
        if ({r, d} !== {3'd0, 32'd1}) begin
            n_fail++; $display("FAIL wcount_1: got resp %h data %h required 0 00000001", r, d);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [2:0] r;
        bready = 1'b0;
        wdata = 32'h12345678; wstrb = 5'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        n_tests++;
        if ({wready, bvalid, awready} !== 3'b001) begin
            n_fail++; $display("FAIL w_first_hold: got wready %b bvalid %b awready %b required 0 0 1", wready, bvalid, awready);
        end
        step();
        awaddr = 8'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        n_tests++;
        if ({bvalid, bresp} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL w_first_b: got bvalid %b bresp %h required 1 0", bvalid, bresp);
        end
        bready = 1'b1;
        step();
        axi_read(8'h4, d, r);
        n_tests++;
        if ({r, d} !== {3'd0, 32'h12345678}) begin
            n_fail++; $display("FAIL reg1: got resp %h data %h required 0 12345678", r, d);
        end
    endtask

    task automatic test_sum();
        logic [31:0] d; logic [2:0] r;
        axi_write(8'h0, 32'hFFFFFFFF, 5'hF, r);
        axi_write(8'h4, 32'h00000002, 5'hF, r);
        axi_read(8'hC, d, r);
        n_tests++;
        if ({r, d} !== {3'd0, 32'h00000001}) begin
            n_fail++; $display("FAIL sum_wrap: got resp %h data %h required 0 00000001", r, d);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d; logic [2:0] r;
        axi_write(8'h0, 32'hDEADBEEF, 5'hF, r);
        axi_write(8'h0, 32'hA5A5A5A5, 5'h5, r);
        n_tests++;
        if (r !== 3'd0) begin
            n_fail++; $display("FAIL partial_bresp: got %h required 0", r);
        end
        axi_read(8'h0, d, r);
        n_tests++;
        if (d !== 32'hDEA5BEA5) begin
            n_fail++; $display("FAIL partial_strobe: got %h required dea5bea5", d);
        end
        // only the ignored strobe MSB set: behaves as an all-zero strobe
        axi_write(8'h4, 32'hFFFFFFFF, 5'h10, r);
        n_tests++;
        if (r !== 3'd0) begin
            n_fail++; $display("FAIL zero_strobe_bresp: got %h required 0", r);
        end
        axi_read(8'h4, d, r);
        n_tests++;
        if (d !== 32'h00000002) begin
            n_fail++; $display("FAIL zero_strobe_reg1: got %h required 00000002", d);
        end
        axi_read(8'h8, d, r);
        n_tests++;
        if (d !== 32'd7) begin
            n_fail++; $display("FAIL wcount_7: got %h required 00000007", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [2:0] r;
        axi_write(8'h8, 32'h55555555, 5'hF, r);
        n_tests++;
        if (r !== 3'd2) begin
            n_fail++; $display("FAIL wr_ro_slverr: got %h required 2", r);
        end
        axi_write(8'hC, 32'h55555555, 5'hF, r);
        n_tests++;
        if (r !== 3'd2) begin
            n_fail++; $display("FAIL wr_sum_slverr: got %h required 2", r);
        end
        axi_write(8'h10, 32'h55555555, 5'hF, r);
        n_tests++;
        if (r !== 3'd3) begin
            n_fail++; $display("FAIL wr_0x10_decerr: got %h required 3", r);
        end
        axi_write(8'h2, 32'h55555555, 5'hF, r);
        n_tests++;
        if (r !== 3'd3) begin
            n_fail++; $display("FAIL wr_unaligned_decerr: got %h required 3", r);
        end
        axi_read(8'h2, d, r);
        n_tests++;
        if ({r, d} !== {3'd3, 32'h0}) begin
            n_fail++; $display("FAIL rd_unaligned: got resp %h data %h required 3 00000000", r, d);
        end
        axi_read(8'h0, d, r);
        n_tests++;
        if (d !== 32'hDEA5BEA5) begin
            n_fail++; $display("FAIL reg0_after_errors: got %h required dea5bea5", d);
        end
        axi_read(8'h10, d, r);
        n_tests++;
        if ({r, d} !== {3'd3, 32'h0}) begin
            n_fail++; $display("FAIL rd_0x10: got resp %h data %h required 3 00000000", r, d);
        end
        axi_read(8'h8, d, r);
        n_tests++;
        if (d !== 32'd7) begin
            n_fail++; $display("FAIL wcount_after_errors: got %h required 00000007", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [2:0] r; logic [31:0] e;
        awaddr = 8'h0; wdata = 32'h11111111; wstrb = 5'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_tests++;
            if (bvalid !== (k % 2 == 0)) begin
                n_fail++; $display("FAIL b2b_write_cycle%0d: got bvalid %b required %b", k, bvalid, (k % 2 == 0));
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        for (int k = 0; k < 3; k++) exp_q.push_back(32'd10);
        araddr = 8'h8; arvalid = 1'b1; rready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_tests++;
            if (rvalid !== (k % 2 == 0)) begin
                n_fail++; $display("FAIL b2b_read_cycle%0d: got rvalid %b required %b", k, rvalid, (k % 2 == 0));
            end
            if (rvalid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                n_tests++;
                if (rdata !== e) begin
                    n_fail++; $display("FAIL b2b_read_data: got %h required %h", rdata, e);
                end
            end
        end
        arvalid = 1'b0;
        step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_read_count: %0d reads missing, required 0", exp_q.size());
        end
        exp_q.delete();
        axi_read(8'h0, d, r);
        n_tests++;
        if (d !== 32'h11111111) begin
            n_fail++; $display("FAIL b2b_reg0: got %h required 11111111", d);
        end
    endtask

    task automatic test_pre_commit_read();
        logic [31:0] d; logic [2:0] r;
        bready = 1'b0; rready = 1'b0;
        awaddr = 8'h0; wdata = 32'h22222222; wstrb = 5'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h0; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_tests++;
        if ({bvalid, rvalid, rdata} !== {1'b1, 1'b1, 32'h11111111}) begin
            n_fail++; $display("FAIL pre_commit_read: got bvalid %b rvalid %b rdata %h required 1 1 11111111",
                               bvalid, rvalid, rdata);
        end
        bready = 1'b1; rready = 1'b1;
        step();
        axi_read(8'h0, d, r);
        n_tests++;
        if (d !== 32'h22222222) begin
            n_fail++; $display("FAIL post_commit_read: got %h required 22222222", d);
        end
        axi_read(8'h8, d, r);
        n_tests++;
        if (d !== 32'd11) begin
            n_fail++; $display("FAIL wcount_11: got %h required 0000000b", d);
        end
    endtask

    task automatic test_backpressure_reset();
        logic [31:0] d; logic [2:0] r;
        bready = 1'b0; rready = 1'b0;
        awaddr = 8'h8; wdata = 32'hFFFFFFFF; wstrb = 5'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h4; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if ({bvalid, bresp, awready, wready, rvalid, rdata, rresp, arready} !==
                {1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 32'd2, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_cycle%0d: got b %b/%h awr %b wr %b r %b/%h/%h arr %b required 1/2 0 0 1/00000002/0 0",
                         k, bvalid, bresp, awready, wready, rvalid, rdata, rresp, arready);
            end
            step();
        end
        areset = 1'b1;
        step();
        n_tests++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pending: got %b required 00000", {bvalid, rvalid, awready, wready, arready});
        end
        areset = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({bvalid, rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL stale_response_%0d: got bvalid %b rvalid %b required 0 0", k, bvalid, rvalid);
            end
        end
        axi_read(8'h0, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_clears_reg0: got %h required 00000000", d);
        end
        axi_read(8'h4, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_clears_reg1: got %h required 00000000", d);
        end
        axi_read(8'h8, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_clears_wcount: got %h required 00000000", d);
        end
    endtask

    initial begin
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; areset = 1'b1;
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_sum();
        test_strobes();
        test_errors();
        test_back_to_back();
        test_pre_commit_read();
        test_backpressure_reset();
        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
